// File: rtl/alu_bist.sv
// ALU self-test sequencer: drives LFSR operand vectors into the ALU
// and compacts its result and flags into a 32-bit MISR signature.
module alu_bist #(
  parameter int unsigned N_VECTORS  = 256,
  parameter logic [31:0] SEED       = 32'hACD4_38F4,
  parameter logic [31:0] GOLDEN_SIG = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_f,
  input  logic        alu_zf,
  input  logic        alu_cf,
  input  logic        alu_of,
  input  logic        alu_sf,
  input  logic        alu_pf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] LAST = 16'(N_VECTORS - 1);
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] B_MASK = 32'h5A5A_A5A5;

  state_e      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] sig_q, sig_d;
  logic [15:0] cnt_q, cnt_d;

  logic [31:0] lfsr_nxt;
  logic [31:0] sig_nxt;
  logic [4:0]  flags;

  assign flags = {alu_zf, alu_cf, alu_of, alu_sf, alu_pf};

  // Galois right-shift LFSR step
  assign lfsr_nxt = {1'b0, lfsr_q[31:1]}
                  ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

  assign sig_nxt = {sig_q[30:0], 1'b0}
                 ^ (sig_q[31] ? MISR_POLY : 32'h0)
                 ^ alu_f
                 ^ {27'b0, flags};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      sig_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          lfsr_d  = SEED;
          sig_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        lfsr_d = lfsr_nxt;
        sig_d  = sig_nxt;
        cnt_d  = cnt_q + 16'd1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = done && (sig_q == GOLDEN_SIG);
  assign signature = sig_q;

  assign alu_a  = busy ? lfsr_q : 32'h0;
  assign alu_b  = busy ? ({lfsr_q[15:0], lfsr_q[31:16]} ^ B_MASK)
                       : 32'h0;
  assign alu_op = busy ? {1'b0, cnt_q[2:0]} : 4'h0;

endmodule

// File: tb/tb_alu_bist.sv
// Scoreboard bench for alu_bist: reference model queues expected
// vectors and signatures; a negedge monitor pops and compares.
module tb_alu_bist;

  localparam int N = 12;
  localparam logic [31:0] SEED = 32'hACD4_38F4;
  localparam logic [31:0] GOLD = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [31:0] signature, alu_a, alu_b, alu_f;
  logic [3:0]  alu_op;
  logic        alu_zf, alu_cf, alu_of, alu_sf, alu_pf;

  int          mode = 0;
  logic [31:0] key = '0;

  int n_chk = 0;
  int n_fail = 0;

  logic [67:0] vq[$];
  logic [31:0] sq[$];

  always #5 clk = ~clk;

  alu_bist #(
    .N_VECTORS(N),
    .SEED(SEED),
    .GOLDEN_SIG(GOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .busy(busy),
    .done(done),
    .pass(pass),
    .signature(signature),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_f(alu_f),
    .alu_zf(alu_zf),
    .alu_cf(alu_cf),
    .alu_of(alu_of),
    .alu_sf(alu_sf),
    .alu_pf(alu_pf)
  );

  function automatic logic [36:0] alu_ref(
    input int m, input logic [31:0] k,
    input logic [31:0] a, input logic [31:0] b,
    input logic [3:0] op);
    logic [32:0] w;
    logic [31:0] f;
    logic cf, of;
    w = '0; f = '0; cf = 1'b0; of = 1'b0;
    case (op)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b}; f = w[31:0]; cf = w[32];
        of = (a[31] == b[31]) && (f[31] != a[31]);
      end
      4'd1: begin
        w = {1'b0, a} - {1'b0, b}; f = w[31:0]; cf = w[32];
        of = (a[31] != b[31]) && (f[31] != a[31]);
      end
      4'd2: f = a & b;
      4'd3: f = a | b;
      4'd4: f = a ^ b;
      4'd5: f = a << b[4:0];
      4'd6: f = a >> b[4:0];
      4'd7: f = $signed(a) >>> b[4:0];
      default: f = '0;
    endcase
    f = f ^ k;
    if (m == 1) return 37'h0;
    if (m == 2) return {5'b00000, 32'h1};
    if (m == 3) return {5'b00001, 32'h1};
    return {f == 32'h0, cf, of, f[31], ~^f, f};
  endfunction

  assign {alu_zf, alu_cf, alu_of, alu_sf, alu_pf, alu_f} =
    alu_ref(mode, key, alu_a, alu_b, alu_op);

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected stream straight from the rules: LFSR, rotate-xor, MISR
  task automatic gen_run();
    logic [31:0] l, s, a, b;
    logic [3:0]  op;
    logic [36:0] r;
    l = SEED; s = '0;
    for (int i = 0; i < N; i++) begin
      a = l;
      b = {l[15:0], l[31:16]} ^ 32'h5A5A_A5A5;
      op = 4'(i % 8);
      vq.push_back({a, b, op});
      r = alu_ref(mode, key, a, b, op);
      s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0)
        ^ r[31:0] ^ {27'b0, r[36:32]};
      l = {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
    end
    sq.push_back(s);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {61'b0, busy, done, pass}, 64'h0);
    chk({nm, "_sig"}, {32'b0, signature}, 64'h0);
    chk({nm, "_ops"}, {alu_a, alu_b} | {60'b0, alu_op}, 64'h0);
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        return;
      end
    end
    chk("done_timeout", 64'h0, 64'h1);
  endtask

  task automatic kick();
    @(negedge clk);
    gen_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor
  logic done_prev = 1'b0;
  int   busy_cnt = 0;
  always @(negedge clk) begin
    logic [67:0] v;
    if (!rst_n) begin
      done_prev = 1'b0;
      busy_cnt = 0;
    end else begin
      chk("busy_done_excl", {63'b0, busy & done}, 64'h0);
      if (busy) begin
        busy_cnt++;
        if (vq.size() == 0) begin
          chk("vec_underflow", 64'h1, 64'h0);
        end else begin
          v = vq.pop_front();
          chk("alu_a", {32'b0, alu_a}, {32'b0, v[67:36]});
          chk("alu_b", {32'b0, alu_b}, {32'b0, v[35:4]});
          chk("alu_op", {60'b0, alu_op}, {60'b0, v[3:0]});
        end
      end else begin
        chk("idle_ops", {alu_a, alu_b} | {60'b0, alu_op}, 64'h0);
        if (!done) chk("pass_idle", {63'b0, pass}, 64'h0);
      end
      if (done && !done_prev) begin
        chk("busy_len", 64'(busy_cnt), 64'(N));
        busy_cnt = 0;
        if (sq.size() == 0) begin
          chk("sig_underflow", 64'h1, 64'h0);
        end else begin
          v = {36'b0, sq.pop_front()};
          chk("signature", {32'b0, signature}, v);
          chk("pass", {63'b0, pass}, {63'b0, v[31:0] == GOLD});
        end
      end
      done_prev = done;
    end
  end

  initial begin
    logic ok;
    logic [31:0] sig1;
    int k;

    #3;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Directed first vectors with the real ALU model
    mode = 0; key = '0;
    kick();
    chk("v0_a", {32'b0, alu_a}, 64'hACD4_38F4);
    chk("v0_b", {32'b0, alu_b}, 64'h62AE_0971);
    chk("v0_op", {60'b0, alu_op}, 64'h0);
    @(negedge clk);
    chk("v1_a", {32'b0, alu_a}, 64'h566A_1C7A);
    chk("v1_op", {60'b0, alu_op}, 64'h1);
    for (int i = 2; i <= 8; i++) @(negedge clk);
    chk("op_wrap", {60'b0, alu_op}, 64'h0);
    wait_done(ok);

    // Zero stub: signature 0, pass high
    mode = 1;
    kick();
    wait_done(ok);
    chk("zero_sig", {32'b0, signature}, 64'h0);
    chk("zero_pass", {63'b0, pass}, 64'h1);

    // Constant stub: shift-in of ones, never reaches bit 31
    mode = 2;
    kick();
    chk("const_sig0", {32'b0, signature}, 64'h0);
    @(negedge clk);
    chk("const_sig1", {32'b0, signature}, 64'h1);
    @(negedge clk);
    chk("const_sig2", {32'b0, signature}, 64'h3);
    wait_done(ok);
    chk("const_final", {32'b0, signature}, 64'(32'h0000_0FFF));
    chk("const_pass", {63'b0, pass}, 64'h0);

    // pf cancels the result bit each step
    mode = 3;
    kick();
    wait_done(ok);
    chk("pf_final", {32'b0, signature}, 64'h0);

    // start pulse during RUN is ignored
    mode = 0; key = $urandom;
    kick();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);

    // start held: back-to-back runs with identical signature
    mode = 0; key = $urandom;
    @(negedge clk);
    gen_run();
    gen_run();
    start = 1'b1;
    wait_done(ok);
    sig1 = signature;
    @(negedge clk);
    chk("held_rerun", {62'b0, busy, done}, 64'h2);
    wait_done(ok);
    start = 1'b0;
    chk("held_same_sig", {32'b0, signature}, {32'b0, sig1});

    // Reset mid-RUN aborts asynchronously
    mode = 0; key = $urandom;
    kick();
    k = $urandom_range(0, N - 4);
    repeat (k) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    vq.delete();
    sq.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Randomised runs after the abort restart from SEED
    for (int r = 0; r < 6; r++) begin
      mode = int'($urandom_range(0, 3));
      key = $urandom;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      kick();
      wait_done(ok);
    end

    repeat (3) @(negedge clk);
    chk("vq_empty", 64'(vq.size()), 64'h0);
    chk("sq_empty", 64'(sq.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
